// File: rtl/axis_wb_ram_writer.sv
// rtl/axis_wb_ram_writer.sv - AXI-stream packet to Wishbone RAM write master
`timescale 1ns/1ps

module axis_wb_ram_writer #(
   parameter int DATA_WIDTH   = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int SELECT_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH    = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [ADDR_WIDTH-1:0]   cfg_base_addr,
   input  logic [LEN_WIDTH-1:0]    cfg_max_words,
   input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
   input  logic [SELECT_WIDTH-1:0] s_axis_tkeep,
   input  logic                    s_axis_tvalid,
   output logic                    s_axis_tready,
   input  logic                    s_axis_tlast,
   output logic [ADDR_WIDTH-1:0]   m_wb_adr_o,
   output logic [DATA_WIDTH-1:0]   m_wb_dat_o,
   output logic                    m_wb_we_o,
   output logic [SELECT_WIDTH-1:0] m_wb_sel_o,
   output logic                    m_wb_stb_o,
   output logic                    m_wb_cyc_o,
   input  logic                    m_wb_ack_i,
   input  logic                    m_wb_err_i,
   output logic                    busy,
   output logic                    done,
   output logic [LEN_WIDTH-1:0]    word_count,
   output logic                    overflow,
   output logic                    bus_error
);

   // One beat advances the word address by the bus width in bytes; the base is
   // forced onto a word boundary so every write is naturally aligned.
   localparam logic [ADDR_WIDTH-1:0] ADR_STEP       = ADDR_WIDTH'(SELECT_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ADR_ALIGN_MASK = ~ADDR_WIDTH'(SELECT_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_WRITE,
      S_DRAIN,
      S_FINISH
   } state_t;

   state_t                  r_state;
   logic [ADDR_WIDTH-1:0]   r_wr_adr;
   logic [LEN_WIDTH-1:0]    r_limit;
   logic                    r_last;
   logic                    r_tready;
   logic [ADDR_WIDTH-1:0]   r_adr;
   logic [DATA_WIDTH-1:0]   r_dat;
   logic [SELECT_WIDTH-1:0] r_sel;
   logic                    r_we;
   logic                    r_stb;
   logic                    r_cyc;
   logic                    r_busy;
   logic                    r_done;
   logic [LEN_WIDTH-1:0]    r_word_count;
   logic                    r_overflow;
   logic                    r_bus_error;

   logic                    w_beat_accept;
   logic                    w_beat_term;
   logic [LEN_WIDTH-1:0]    w_count_next;

   assign w_beat_accept = s_axis_tvalid & r_tready;
   assign w_beat_term   = m_wb_ack_i | m_wb_err_i;
   assign w_count_next  = r_word_count + LEN_WIDTH'(1);

   assign s_axis_tready = r_tready;
   assign m_wb_adr_o    = r_adr;
   assign m_wb_dat_o    = r_dat;
   assign m_wb_sel_o    = r_sel;
   assign m_wb_we_o     = r_we;
   assign m_wb_stb_o    = r_stb;
   assign m_wb_cyc_o    = r_cyc;
   assign busy          = r_busy;
   assign done          = r_done;
   assign word_count    = r_word_count;
   assign overflow      = r_overflow;
   assign bus_error     = r_bus_error;

   // Transfer sequencer: every output is a register set on the edge that
   // enters the state owning it, so the bus sees glitch-free levels.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= S_IDLE;
         r_wr_adr     <= '0;
         r_limit      <= '0;
         r_last       <= 1'b0;
         r_tready     <= 1'b0;
         r_adr        <= '0;
         r_dat        <= '0;
         r_sel        <= '0;
         r_we         <= 1'b0;
         r_stb        <= 1'b0;
         r_cyc        <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_word_count <= '0;
         r_overflow   <= 1'b0;
         r_bus_error  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_word_count <= '0;
                  r_overflow   <= 1'b0;
                  r_bus_error  <= 1'b0;
                  if (cfg_max_words != '0) begin
                     r_wr_adr <= cfg_base_addr & ADR_ALIGN_MASK;
                     r_limit  <= cfg_max_words;
                     r_busy   <= 1'b1;
                     r_tready <= 1'b1;
                     r_state  <= S_ACCEPT;
                  end else begin
                     // Empty transfer: report completion without leaving IDLE.
                     r_done <= 1'b1;
                  end
               end
            end

            S_ACCEPT: begin
               if (w_beat_accept) begin
                  r_tready <= 1'b0;
                  r_adr    <= r_wr_adr;
                  r_dat    <= s_axis_tdata;
                  r_sel    <= s_axis_tkeep;
                  r_last   <= s_axis_tlast;
                  r_cyc    <= 1'b1;
                  r_stb    <= 1'b1;
                  r_we     <= 1'b1;
                  r_state  <= S_WRITE;
               end
            end

            S_WRITE: begin
               // Dropping stb on the terminating edge guarantees a low cycle
               // before the next strobe, which the RAM's ack gating relies on.
               if (w_beat_term) begin
                  r_cyc        <= 1'b0;
                  r_stb        <= 1'b0;
                  r_we         <= 1'b0;
                  r_word_count <= w_count_next;
                  r_wr_adr     <= r_wr_adr + ADR_STEP;
                  if (m_wb_err_i) begin
                     r_bus_error <= 1'b1;
                  end
                  if (r_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_FINISH;
                  end else if (m_wb_err_i || r_bus_error) begin
                     r_tready <= 1'b1;
                     r_state  <= S_DRAIN;
                  end else if (w_count_next == r_limit) begin
                     r_overflow <= 1'b1;
                     r_tready   <= 1'b1;
                     r_state    <= S_DRAIN;
                  end else begin
                     r_tready <= 1'b1;
                     r_state  <= S_ACCEPT;
                  end
               end
            end

            S_DRAIN: begin
               // Swallow the rest of the packet so the producer is not stalled.
               if (s_axis_tvalid && s_axis_tlast) begin
                  r_tready <= 1'b0;
                  r_done   <= 1'b1;
                  r_state  <= S_FINISH;
               end
            end

            S_FINISH: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_wb_ram_writer.sv
// tb/tb_axis_wb_ram_writer.sv - randomized self-checking bench for axis_wb_ram_writer
`timescale 1ns/1ps

module tb_axis_wb_ram_writer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] cfg_base_addr = '0;
   logic [15:0] cfg_max_words = '0;
   logic [31:0] s_axis_tdata = '0;
   logic [3:0]  s_axis_tkeep = '0;
   logic        s_axis_tvalid = 1'b0;
   logic        s_axis_tready;
   logic        s_axis_tlast = 1'b0;
   logic [15:0] m_wb_adr_o;
   logic [31:0] m_wb_dat_o;
   logic        m_wb_we_o;
   logic [3:0]  m_wb_sel_o;
   logic        m_wb_stb_o;
   logic        m_wb_cyc_o;
   logic        m_wb_ack_i;
   logic        m_wb_err_i;
   logic        busy;
   logic        done;
   logic [15:0] word_count;
   logic        overflow;
   logic        bus_error;

   always #5 clk = ~clk;

   axis_wb_ram_writer #(
      .DATA_WIDTH(32), .ADDR_WIDTH(16), .SELECT_WIDTH(4), .LEN_WIDTH(16)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .cfg_base_addr(cfg_base_addr), .cfg_max_words(cfg_max_words),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast),
      .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o), .m_wb_we_o(m_wb_we_o),
      .m_wb_sel_o(m_wb_sel_o), .m_wb_stb_o(m_wb_stb_o), .m_wb_cyc_o(m_wb_cyc_o),
      .m_wb_ack_i(m_wb_ack_i), .m_wb_err_i(m_wb_err_i),
      .busy(busy), .done(done), .word_count(word_count),
      .overflow(overflow), .bus_error(bus_error)
   );

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [15:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
   } wr_t;

   // RAM as written through the bus, and the RAM the reference model predicts.
   bit [31:0] ram     [16384];
   bit [31:0] ref_ram [16384];
   wr_t       obs_q[$];
   wr_t       exp_q[$];
   int        exp_wc;
   bit        exp_of;
   bit        exp_be;
   logic [31:0] b_data [32];
   logic [3:0]  b_keep [32];

   // Slave behaviour knobs, written only by the test tasks.
   int ack_delay    = 0;
   int err_at       = 0;
   bit err_with_ack = 0;

   int slv_idx;
   int wait_cnt;

   function automatic bit [31:0] merge(input bit [31:0] old, input logic [31:0] d, input logic [3:0] s);
      bit [31:0] r;
      for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : old[8*b +: 8];
      return r;
   endfunction

   // Registered-ack RAM port with optional wait states and error injection.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_wb_ack_i <= 1'b0;
         m_wb_err_i <= 1'b0;
         wait_cnt   <= 0;
         slv_idx    <= 0;
      end else begin
         m_wb_ack_i <= 1'b0;
         m_wb_err_i <= 1'b0;
         if (start && !busy) begin
            slv_idx <= 0;
            obs_q.delete();
         end else if (m_wb_cyc_o && m_wb_stb_o && !m_wb_ack_i && !m_wb_err_i) begin
            if (wait_cnt < ack_delay) begin
               wait_cnt <= wait_cnt + 1;
            end else begin
               wait_cnt <= 0;
               slv_idx  <= slv_idx + 1;
               obs_q.push_back({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o});
               if (slv_idx + 1 == err_at) begin
                  m_wb_err_i <= 1'b1;
                  m_wb_ack_i <= err_with_ack;
               end else begin
                  m_wb_ack_i <= 1'b1;
                  ram[m_wb_adr_o[15:2]] <= merge(ram[m_wb_adr_o[15:2]], m_wb_dat_o, m_wb_sel_o);
               end
            end
         end
      end
   end

   // Protocol observer sampled on the falling edge.
   int   cyc_no = 0;
   int   done_cnt = 0;
   int   viol_cnt = 0;
   int   hs_q[$];
   logic prev_stb = 1'b0;
   logic prev_term = 1'b0;
   logic prev_done = 1'b0;
   logic [51:0] prev_bus = '0;

   always @(negedge clk) begin
      cyc_no++;
      if (start && !busy) hs_q.delete();
      if (s_axis_tvalid && s_axis_tready) hs_q.push_back(cyc_no);
      if (done) done_cnt++;
      if (done && prev_done) viol_cnt++;
      if (s_axis_tready && m_wb_cyc_o) viol_cnt++;
      if (m_wb_we_o !== m_wb_cyc_o) viol_cnt++;
      if (m_wb_stb_o && prev_stb && prev_term) viol_cnt++;
      if (m_wb_stb_o && prev_stb && !prev_term && ({m_wb_adr_o, m_wb_dat_o, m_wb_sel_o} != prev_bus)) viol_cnt++;
      prev_stb  = m_wb_stb_o;
      prev_term = m_wb_ack_i | m_wb_err_i;
      prev_done = done;
      prev_bus  = {m_wb_adr_o, m_wb_dat_o, m_wb_sel_o};
   end

   // Reference: walk the packet applying the writer's documented rules.
   task automatic model_transfer(input logic [15:0] base, input int limit, input int nb, input int err_idx);
      logic [15:0] a;
      bit stop;
      exp_q.delete();
      exp_wc = 0; exp_of = 0; exp_be = 0; stop = 0;
      for (int i = 0; i < nb; i++) begin
         if (!stop) begin
            a = (base & 16'hFFFC) + 16'(exp_wc * 4);
            exp_q.push_back({a, b_data[i], b_keep[i]});
            exp_wc++;
            if (exp_wc == err_idx) exp_be = 1;
            else ref_ram[a[15:2]] = merge(ref_ram[a[15:2]], b_data[i], b_keep[i]);
            if (i == nb - 1) stop = 1;
            else if (exp_be) stop = 1;
            else if (exp_wc == limit) begin exp_of = 1; stop = 1; end
         end
      end
   endtask

   function automatic int wr_diff();
      int d;
      int n;
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      d = (obs_q.size() > exp_q.size()) ? obs_q.size() - exp_q.size() : exp_q.size() - obs_q.size();
      for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) d++;
      return d;
   endfunction

   function automatic int mem_diff();
      int d = 0;
      for (int i = 0; i < 16384; i++) if (ram[i] != ref_ram[i]) d++;
      return d;
   endfunction

   task automatic pulse_start(input logic [15:0] base, input logic [15:0] limit);
      @(posedge clk); #1;
      cfg_base_addr = base;
      cfg_max_words = limit;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic run_xfer(input logic [15:0] base, input logic [15:0] limit, input int nb,
                           input int gap_max, output int tmo);
      int w;
      int g;
      tmo = 0;
      pulse_start(base, limit);
      for (int i = 0; i < nb; i++) begin
         g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
         if (g > 0) begin
            s_axis_tvalid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = b_data[i];
         s_axis_tkeep  = b_keep[i];
         s_axis_tlast  = (i == nb - 1);
         w = 0;
         while (1) begin
            @(negedge clk);
            if (s_axis_tready) break;
            w++;
            if (w > 200) begin tmo++; break; end
         end
         @(posedge clk); #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      w = 0;
      while (busy && w < 300) begin @(negedge clk); w++; end
      if (busy) tmo++;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #12;
      n_checks++; if (s_axis_tready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin n_fail++;
         $display("FAIL reset_ctrl: tready=%b busy=%b done=%b, required 0/0/0", s_axis_tready, busy, done); end
      n_checks++; if (m_wb_cyc_o !== 1'b0 || m_wb_stb_o !== 1'b0 || m_wb_we_o !== 1'b0) begin n_fail++;
         $display("FAIL reset_bus: cyc=%b stb=%b we=%b, required 0/0/0", m_wb_cyc_o, m_wb_stb_o, m_wb_we_o); end
      n_checks++; if (m_wb_adr_o !== 16'h0 || m_wb_dat_o !== 32'h0 || m_wb_sel_o !== 4'h0) begin n_fail++;
         $display("FAIL reset_data: adr=%h dat=%h sel=%h, required zero", m_wb_adr_o, m_wb_dat_o, m_wb_sel_o); end
      n_checks++; if (word_count !== 16'h0 || overflow !== 1'b0 || bus_error !== 1'b0) begin n_fail++;
         $display("FAIL reset_status: count=%0d ovf=%b err=%b, required 0/0/0", word_count, overflow, bus_error); end
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      int tmo, dc0, v0, bad;
      ack_delay = 0; err_at = 0; err_with_ack = 0;
      for (int i = 0; i < 4; i++) begin b_data[i] = 32'h1111_1111 * (i + 1); b_keep[i] = 4'hF; end
      model_transfer(16'h0100, 8, 4, 0);
      dc0 = done_cnt; v0 = viol_cnt;
      run_xfer(16'h0100, 16'd8, 4, 1, tmo);
      bad = (obs_q.size() != 4) ? 1 : 0;
      for (int i = 0; i < obs_q.size(); i++)
         if (obs_q[i].adr !== 16'h0100 + 16'(4 * i) || obs_q[i].sel !== 4'hF || obs_q[i].dat !== 32'h1111_1111 * (i + 1)) bad++;
      n_checks++; if (bad != 0 || tmo != 0) begin n_fail++;
         $display("FAIL basic_writes: %0d bad writes, %0d timeouts, required 0/0", bad, tmo); end
      n_checks++; if (int'(word_count) != 4 || overflow !== 1'b0 || bus_error !== 1'b0) begin n_fail++;
         $display("FAIL basic_status: count=%0d ovf=%b err=%b, required 4/0/0", word_count, overflow, bus_error); end
      n_checks++; if (done_cnt - dc0 != 1 || viol_cnt != v0) begin n_fail++;
         $display("FAIL basic_done: %0d done pulses %0d violations, required 1/0", done_cnt - dc0, viol_cnt - v0); end
      n_checks++; if (mem_diff() != 0) begin n_fail++;
         $display("FAIL basic_ram: %0d words differ, required 0", mem_diff()); end
   endtask

   task automatic test_throughput();
      int tmo, v0, bad;
      ack_delay = 0; err_at = 0;
      for (int i = 0; i < 6; i++) begin b_data[i] = $urandom; b_keep[i] = 4'hF; end
      model_transfer(16'h2000, 16, 6, 0);
      v0 = viol_cnt;
      run_xfer(16'h2000, 16'd16, 6, 0, tmo);
      bad = (hs_q.size() != 6) ? 1 : 0;
      for (int i = 1; i < hs_q.size(); i++) if (hs_q[i] - hs_q[i-1] != 3) bad++;
      n_checks++; if (bad != 0 || tmo != 0) begin n_fail++;
         $display("FAIL thru_spacing: %0d bad handshake gaps (%0d handshakes), required 0", bad, hs_q.size()); end
      n_checks++; if (viol_cnt != v0) begin n_fail++;
         $display("FAIL thru_protocol: %0d stb/tready violations, required 0", viol_cnt - v0); end
      n_checks++; if (wr_diff() != 0) begin n_fail++;
         $display("FAIL thru_writes: %0d mismatching writes, required 0", wr_diff()); end
   endtask

   task automatic test_wrap();
      int tmo, bad;
      logic [15:0] exp_adr [4];
      exp_adr[0] = 16'hFFF8; exp_adr[1] = 16'hFFFC; exp_adr[2] = 16'h0000; exp_adr[3] = 16'h0004;
      ack_delay = 1; err_at = 0;
      for (int i = 0; i < 4; i++) begin b_data[i] = 32'hAAAA_5555 + i; b_keep[i] = 4'hF; end
      model_transfer(16'hFFF8, 4, 4, 0);
      run_xfer(16'hFFF8, 16'd4, 4, 1, tmo);
      for (int i = 0; i < 4; i++) b_data[i] = 32'h1234_BEEF + i;
      b_keep[1] = 4'h3;
      model_transfer(16'hFFFA, 4, 4, 0);
      run_xfer(16'hFFFA, 16'd4, 4, 0, tmo);
      bad = (obs_q.size() != 4) ? 1 : 0;
      for (int i = 0; i < obs_q.size(); i++) if (obs_q[i].adr !== exp_adr[i]) bad++;
      n_checks++; if (bad != 0 || tmo != 0) begin n_fail++;
         $display("FAIL wrap_addr: %0d wrong addresses, %0d timeouts, required 0/0", bad, tmo); end
      n_checks++; if (obs_q.size() > 1 && obs_q[1].sel !== 4'h3) begin n_fail++;
         $display("FAIL wrap_sel: sel=%h, required 3", obs_q[1].sel); end
      n_checks++; if (ram[16'hFFFC >> 2] !== 32'hAAAA_BEF0) begin n_fail++;
         $display("FAIL wrap_partial: word=%h, required aaaabef0", ram[16'hFFFC >> 2]); end
      n_checks++; if (mem_diff() != 0 || overflow !== 1'b0 || int'(word_count) != 4) begin n_fail++;
         $display("FAIL wrap_status: %0d ram diffs, ovf=%b count=%0d, required 0/0/4", mem_diff(), overflow, word_count); end
   endtask

   task automatic test_overflow();
      int tmo, dc0;
      ack_delay = 0; err_at = 0;
      for (int i = 0; i < 5; i++) begin b_data[i] = $urandom; b_keep[i] = 4'(i + 1); end
      model_transfer(16'h0400, 2, 5, 0);
      dc0 = done_cnt;
      fork
         run_xfer(16'h0400, 16'd2, 5, 1, tmo);
         begin
            repeat (4) @(posedge clk);
            #2;
            cfg_base_addr = 16'h3000; cfg_max_words = 16'd9; start = 1'b1;
            @(posedge clk); #2;
            start = 1'b0;
         end
      join
      n_checks++; if (wr_diff() != 0 || obs_q.size() != 2) begin n_fail++;
         $display("FAIL ovf_writes: %0d writes (%0d mismatching), required 2/0", obs_q.size(), wr_diff()); end
      n_checks++; if (overflow !== 1'b1 || bus_error !== 1'b0 || int'(word_count) != 2) begin n_fail++;
         $display("FAIL ovf_status: ovf=%b err=%b count=%0d, required 1/0/2", overflow, bus_error, word_count); end
      n_checks++; if (hs_q.size() != 5 || done_cnt - dc0 != 1 || tmo != 0) begin n_fail++;
         $display("FAIL ovf_drain: %0d beats consumed, %0d done pulses, required 5/1", hs_q.size(), done_cnt - dc0); end
   endtask

   task automatic test_bus_error(input bit with_ack);
      int tmo, dc0;
      ack_delay = 0; err_at = 2; err_with_ack = with_ack;
      for (int i = 0; i < 4; i++) begin b_data[i] = $urandom; b_keep[i] = 4'hF; end
      model_transfer(16'h0800, 8, 4, 2);
      dc0 = done_cnt;
      run_xfer(16'h0800, 16'd8, 4, 0, tmo);
      n_checks++; if (wr_diff() != 0 || obs_q.size() != 2) begin n_fail++;
         $display("FAIL err_writes(ack=%0d): %0d writes (%0d mismatching), required 2/0", with_ack, obs_q.size(), wr_diff()); end
      n_checks++; if (bus_error !== 1'b1 || overflow !== 1'b0 || int'(word_count) != 2) begin n_fail++;
         $display("FAIL err_status(ack=%0d): err=%b ovf=%b count=%0d, required 1/0/2", with_ack, bus_error, overflow, word_count); end
      n_checks++; if (hs_q.size() != 4 || done_cnt - dc0 != 1 || mem_diff() != 0 || tmo != 0) begin n_fail++;
         $display("FAIL err_drain(ack=%0d): beats=%0d done=%0d ramdiff=%0d, required 4/1/0", with_ack, hs_q.size(), done_cnt - dc0, mem_diff()); end
      err_at = 0; err_with_ack = 0;
   endtask

   task automatic test_last_at_limit();
      int tmo, dc0;
      ack_delay = 0; err_at = 0;
      for (int i = 0; i < 3; i++) begin b_data[i] = $urandom; b_keep[i] = 4'hF; end
      model_transfer(16'h0C00, 3, 3, 0);
      dc0 = done_cnt;
      run_xfer(16'h0C00, 16'd3, 3, 0, tmo);
      n_checks++; if (overflow !== 1'b0 || int'(word_count) != 3 || done_cnt - dc0 != 1 || wr_diff() != 0) begin n_fail++;
         $display("FAIL last_at_limit: ovf=%b count=%0d done=%0d, required 0/3/1", overflow, word_count, done_cnt - dc0); end
   endtask

   task automatic test_random();
      int tmo, dc0, v0, limit, nb;
      logic [15:0] base;
      for (int it = 0; it < 10; it++) begin
         base = 16'($urandom);
         limit = $urandom_range(6, 1);
         nb = $urandom_range(8, 1);
         err_at = ($urandom_range(3, 0) == 0) ? int'($urandom_range(nb, 1)) : 0;
         err_with_ack = 1'($urandom);
         ack_delay = $urandom_range(2, 0);
         for (int i = 0; i < nb; i++) begin b_data[i] = $urandom; b_keep[i] = 4'($urandom); end
         model_transfer(base, limit, nb, err_at);
         dc0 = done_cnt; v0 = viol_cnt;
         run_xfer(base, 16'(limit), nb, 2, tmo);
         n_checks++; if (wr_diff() != 0 || tmo != 0) begin n_fail++;
            $display("FAIL rand%0d_writes: %0d mismatching writes %0d timeouts, required 0/0", it, wr_diff(), tmo); end
         n_checks++; if (int'(word_count) != exp_wc || overflow !== exp_of || bus_error !== exp_be) begin n_fail++;
            $display("FAIL rand%0d_status: count=%0d ovf=%b err=%b, required %0d/%b/%b", it, word_count, overflow, bus_error, exp_wc, exp_of, exp_be); end
         n_checks++; if (done_cnt - dc0 != 1 || viol_cnt != v0 || mem_diff() != 0) begin n_fail++;
            $display("FAIL rand%0d_misc: done=%0d viol=%0d ramdiff=%0d, required 1/0/0", it, done_cnt - dc0, viol_cnt - v0, mem_diff()); end
      end
      err_at = 0; err_with_ack = 0;
   endtask

   task automatic test_reset_mid_write();
      int w, dc0;
      ack_delay = 3; err_at = 0;
      pulse_start(16'h0200, 16'd4);
      s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD_BEEF; s_axis_tkeep = 4'hF; s_axis_tlast = 1'b0;
      w = 0;
      while (w < 50) begin @(negedge clk); if (s_axis_tready) break; w++; end
      @(posedge clk); #1;
      s_axis_tvalid = 1'b0;
      @(negedge clk);
      n_checks++; if (m_wb_stb_o !== 1'b1) begin n_fail++;
         $display("FAIL rst_pre: stb=%b, required 1", m_wb_stb_o); end
      dc0 = done_cnt;
      rst_n = 1'b0;
      #1;
      n_checks++; if (m_wb_cyc_o !== 1'b0 || m_wb_stb_o !== 1'b0 || s_axis_tready !== 1'b0 || busy !== 1'b0) begin n_fail++;
         $display("FAIL rst_async: cyc=%b stb=%b tready=%b busy=%b, required 0", m_wb_cyc_o, m_wb_stb_o, s_axis_tready, busy); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      n_checks++; if (done_cnt != dc0 || obs_q.size() != 0) begin n_fail++;
         $display("FAIL rst_nodone: %0d done pulses %0d writes, required 0/0", done_cnt - dc0, obs_q.size()); end
      ack_delay = 0;
      pulse_start(16'h0040, 16'd0);
      n_checks++; if (done !== 1'b1 || busy !== 1'b0 || word_count !== 16'h0) begin n_fail++;
         $display("FAIL zero_done: done=%b busy=%b count=%0d, required 1/0/0", done, busy, word_count); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0 || m_wb_cyc_o !== 1'b0 || obs_q.size() != 0) begin n_fail++;
         $display("FAIL zero_after: done=%b cyc=%b writes=%0d, required 0/0/0", done, m_wb_cyc_o, obs_q.size()); end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_throughput();
      test_wrap();
      test_overflow();
      test_bus_error(1'b0);
      test_bus_error(1'b1);
      test_last_at_limit();
      test_random();
      test_reset_mid_write();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
